// File: rtl/output_fifo_writer.sv
// output_fifo_writer: queues result/status pairs and writes them pair-aligned to two downstream FIFOs (OUT_WR_COUNT_EN builds the tokens_written counter)
module output_fifo_writer #(
  parameter int word_size = 16,
  parameter int buffer_size = 1024,
  parameter int queue_depth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_wr_output_fifo,
  input  logic [word_size-1:0] result,
  input  logic [word_size-1:0] status,
  input  logic [word_size-1:0] pop_out_fifo_result,
  input  logic [word_size-1:0] pop_out_fifo_status,
  output logic                 wr_out_result,
  output logic                 wr_out_status,
  output logic [word_size-1:0] data_out_result,
  output logic [word_size-1:0] data_out_status,
  output logic                 busy,
  output logic                 overflow,
  output logic [word_size-1:0] tokens_written
);
  localparam int aw = $clog2(queue_depth);
  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;
  state_t state, state_next;
  logic [2*word_size-1:0] mem [queue_depth];
  logic [aw-1:0] head, tail;
  logic [aw:0] count, count_next;
  logic enq, deq, full, space, wr;
  assign full = count[aw];
  assign deq = state == WRITE;
  assign enq = en_wr_output_fifo && (!full || deq);
  assign space = 32'(pop_out_fifo_result) < buffer_size && 32'(pop_out_fifo_status) < buffer_size;
  assign count_next = count + (aw+1)'(enq) - (aw+1)'(deq);
  assign wr_out_result = wr;
  assign wr_out_status = wr;
  assign busy = count != '0 || state != IDLE;
  // next state: wait for a queued pair, stall on downstream full, one-cycle write
  always_comb begin
    state_next = state;
    state_next = state == IDLE  ? (count != '0 ? CHECK : IDLE) :
                 state == CHECK ? (space ? WRITE : CHECK) :
                 (count_next != '0 ? CHECK : IDLE);
  end
  // queue storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= {result, status};
  end
  // state, queue pointers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      wr <= 1'b0;
      data_out_result <= '0;
      data_out_status <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (enq) tail <= tail + aw'(1);
      if (deq) head <= head + aw'(1);
      wr <= state == CHECK && space;
      if (state == CHECK && space) {data_out_result, data_out_status} <= mem[head];
      if (en_wr_output_fifo && full && !deq) overflow <= 1'b1;
    end
  end
`ifdef OUT_WR_COUNT_EN
  logic [word_size-1:0] tokens;
  // count every completed write, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tokens <= '0;
    else if (deq) tokens <= tokens + word_size'(1);
  end
  assign tokens_written = tokens;
`else
  assign tokens_written = '0;
`endif
endmodule

// File: tb/tb_output_fifo_writer.sv
// tb_output_fifo_writer: scoreboard bench for output_fifo_writer
module tb_output_fifo_writer;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [15:0] result = '0, status = '0, pop_r = '0, pop_s = '0;
  logic wr_r, wr_s, busy, overflow;
  logic [15:0] dout_r, dout_s, tokens;
  int checks = 0, fails = 0, nwr = 0, cyc = 0;
  logic [31:0] sb [$];
  int wr_cyc [$];
`ifdef OUT_WR_COUNT_EN
  localparam int cnt_en = 1;
`else
  localparam int cnt_en = 0;
`endif

  output_fifo_writer dut (
    .clk(clk), .rst(rst), .en_wr_output_fifo(en), .result(result), .status(status),
    .pop_out_fifo_result(pop_r), .pop_out_fifo_status(pop_s),
    .wr_out_result(wr_r), .wr_out_status(wr_s),
    .data_out_result(dout_r), .data_out_status(dout_s),
    .busy(busy), .overflow(overflow), .tokens_written(tokens)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every observed write
  always @(negedge clk) begin
    cyc++;
    if (wr_r || wr_s) begin
      check("wr_pair_aligned", 32'(wr_r), 32'(wr_s));
      nwr++;
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got %h/%h expected none", dout_r, dout_s);
      end else check("write_data", {dout_r, dout_s}, sb.pop_front());
    end
  end

  task automatic req(input logic [15:0] r, input logic [15:0] s, input bit push);
    en = 1'b1;
    result = r;
    status = s;
    if (push) sb.push_back({r, s});
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    int n0, k;
    repeat (2) @(negedge clk);
    check("rst_wr", 32'(wr_r), 0);
    check("rst_data", {dout_r, dout_s}, 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_tokens", 32'(tokens), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    // single request latency
    req(16'h0005, 16'h0000, 1);
    check("lat_n0", 32'(wr_r), 0);
    @(negedge clk);
    check("lat_n1", 32'(wr_r), 0);
    @(negedge clk);
    check("lat_n2_wr", 32'({wr_r, wr_s}), 3);
    check("lat_n2_data", {dout_r, dout_s}, 32'h0005_0000);
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("hold_data", {dout_r, dout_s}, 32'h0005_0000);
    // four back-to-back requests
    wr_cyc.delete();
    for (int i = 1; i <= 4; i++) req(16'(i), 16'(i + 16), 1);
    repeat (12) @(negedge clk);
    check("b2b_count", wr_cyc.size(), 4);
    for (int i = 1; i < 4 && i < wr_cyc.size(); i++) check("b2b_spacing", wr_cyc[i] - wr_cyc[i-1], 2);
    check("b2b_overflow", 32'(overflow), 0);
    check("b2b_drained", sb.size(), 0);
    // status FIFO full stall
    pop_s = 16'd1024;
    n0 = nwr;
    req(16'h000A, 16'h000B, 1);
    repeat (10) @(negedge clk);
    check("stall_no_write", nwr, n0);
    check("stall_busy", 32'(busy), 1);
    pop_s = 16'd1023;
    repeat (3) @(negedge clk);
    check("stall_release", nwr, n0 + 1);
    // overflow with downstream stalled
    pop_r = 16'd1024;
    n0 = nwr;
    for (int i = 0; i < 5; i++) req(16'(16'h0100 + i), 16'(16'h0200 + i), i < 4);
    @(negedge clk);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_no_write", nwr, n0);
    pop_r = 16'd0;
    repeat (12) @(negedge clk);
    check("ovf_writes", nwr, n0 + 4);
    check("ovf_drained", sb.size(), 0);
    // reset during WRITE
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_overflow", 32'(overflow), 0);
    pop_r = 16'd1024;
    for (int i = 0; i < 3; i++) req(16'(16'h0300 + i), 16'(16'h0400 + i), 1);
    pop_r = 16'd0;
    k = 0;
    while (!wr_r && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_write_seen", 32'(wr_r), 1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_wr", 32'({wr_r, wr_s}), 0);
    check("rst_async_busy", 32'(busy), 0);
    sb.delete();
    n0 = nwr;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_writes", nwr, n0);
    check("rst_tokens_cleared", 32'(tokens), 0);
    // token counter
    for (int i = 0; i < 3; i++) req(16'(16'h0500 + i), 16'(16'h0600 + i), 1);
    repeat (10) @(negedge clk);
    check("tok_writes", nwr, n0 + 3);
    check("tok_count", 32'(tokens), cnt_en ? 3 : 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
